// File: rtl/decoder_scan_driver.sv
// decoder_scan_driver: steps a 3-to-8 decoder's a/b/c select through the
// enabled channels of an 8-bit mask, holding each for a programmable dwell.
// Single-shot or continuous framing with a one-cycle frame_done pulse.
// Optional build macro: SCAN_BLANK_EN inserts one break-before-make blank
// cycle between channels and at each frame end.
module decoder_scan_driver #(
    parameter int unsigned DWELL_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               stop,
    input  logic               cont,
    input  logic [7:0]         mask,
    input  logic [DWELL_W-1:0] dwell,
    output logic               a,
    output logic               b,
    output logic               c,
    output logic               sel_valid,
    output logic               busy,
    output logic               frame_done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        BLANK = 2'd2
    } state_t;

    state_t             state;
    logic [7:0]         mask_q;
    logic [2:0]         sel;
    logic [DWELL_W-1:0] cnt;

`ifdef SCAN_BLANK_EN
    logic [2:0]         pend_sel;
    logic               end_pend;
`endif

    logic [DWELL_W-1:0] dwell_eff;
    logic [3:0]         first_new;
    logic [3:0]         next_cur;

    // Lowest set bit of m at index >= lo; result is {found, index}
    function automatic logic [3:0] next_set(input logic [7:0] m, input logic [3:0] lo);
        logic [3:0] r;
        r = 4'd0;
        for (int i = 7; i >= 0; i--) begin
            if (m[i] && (4'(i) >= lo)) begin
                r = {1'b1, 3'(i)};
            end
        end
        return r;
    endfunction

    // Dwell of zero behaves as one cycle
    assign dwell_eff = (dwell == '0) ? DWELL_W'(1) : dwell;

    // First channel of a freshly latched mask, and next channel in the current frame
    assign first_new = next_set(mask, 4'd0);
    assign next_cur  = next_set(mask_q, {1'b0, sel} + 4'd1);

    // Decoder select lines come straight from the registered channel index
    assign a = sel[2];
    assign b = sel[1];
    assign c = sel[0];

    // Scan state machine with registered outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            mask_q     <= 8'd0;
            sel        <= 3'd0;
            cnt        <= '0;
            sel_valid  <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
`ifdef SCAN_BLANK_EN
            pend_sel   <= 3'd0;
            end_pend   <= 1'b0;
`endif
        end else begin
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && !stop && (mask != 8'd0)) begin
                        mask_q    <= mask;
                        sel       <= first_new[2:0];
                        cnt       <= dwell_eff;
                        sel_valid <= 1'b1;
                        busy      <= 1'b1;
                        state     <= SCAN;
                    end
                end

                SCAN: begin
                    if (stop) begin
                        state     <= IDLE;
                        sel       <= 3'd0;
                        cnt       <= '0;
                        sel_valid <= 1'b0;
                        busy      <= 1'b0;
                    end else if (cnt != DWELL_W'(1)) begin
                        cnt <= cnt - DWELL_W'(1);
                    end else if (next_cur[3]) begin
`ifdef SCAN_BLANK_EN
                        state     <= BLANK;
                        sel_valid <= 1'b0;
                        pend_sel  <= next_cur[2:0];
                        end_pend  <= 1'b0;
`else
                        sel <= next_cur[2:0];
                        cnt <= dwell_eff;
`endif
                    end else begin
                        frame_done <= 1'b1;
                        if (cont && (mask != 8'd0)) begin
                            mask_q <= mask;
`ifdef SCAN_BLANK_EN
                            state     <= BLANK;
                            sel_valid <= 1'b0;
                            pend_sel  <= first_new[2:0];
                            end_pend  <= 1'b0;
`else
                            sel <= first_new[2:0];
                            cnt <= dwell_eff;
`endif
                        end else begin
`ifdef SCAN_BLANK_EN
                            // Frame-end blank holds abc; drop to IDLE afterwards
                            state     <= BLANK;
                            sel_valid <= 1'b0;
                            end_pend  <= 1'b1;
`else
                            state     <= IDLE;
                            sel       <= 3'd0;
                            cnt       <= '0;
                            sel_valid <= 1'b0;
                            busy      <= 1'b0;
`endif
                        end
                    end
                end

`ifdef SCAN_BLANK_EN
                BLANK: begin
                    if (stop || end_pend) begin
                        state     <= IDLE;
                        sel       <= 3'd0;
                        cnt       <= '0;
                        sel_valid <= 1'b0;
                        busy      <= 1'b0;
                        end_pend  <= 1'b0;
                    end else begin
                        state     <= SCAN;
                        sel       <= pend_sel;
                        cnt       <= dwell_eff;
                        sel_valid <= 1'b1;
                    end
                end
`endif

                default: begin
                    state     <= IDLE;
                    sel       <= 3'd0;
                    cnt       <= '0;
                    sel_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_decoder_scan_driver.sv
// Scoreboard bench for decoder_scan_driver: stimulus pushes per-cycle expected
// outputs tagged with the cycle they must appear in; a monitor on the falling
// edge pops and compares them.
module tb_decoder_scan_driver;

    localparam int unsigned DWELL_W = 8;

    logic               clk;
    logic               rst_n;
    logic               start;
    logic               stop;
    logic               cont;
    logic [7:0]         mask;
    logic [DWELL_W-1:0] dwell;
    logic               a;
    logic               b;
    logic               c;
    logic               sel_valid;
    logic               busy;
    logic               frame_done;

    decoder_scan_driver #(.DWELL_W(DWELL_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .stop       (stop),
        .cont       (cont),
        .mask       (mask),
        .dwell      (dwell),
        .a          (a),
        .b          (b),
        .c          (c),
        .sel_valid  (sel_valid),
        .busy       (busy),
        .frame_done (frame_done)
    );

    typedef struct {
        int         t;
        string      nm;
        logic       v;
        logic       bz;
        logic       fd;
        logic [2:0] s;
    } exp_t;

    exp_t q[$];
    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Monitor: compare every expectation due in the current cycle
    always @(negedge clk) begin
        while (q.size() > 0 && q[0].t <= cyc) begin
            exp_t e;
            e = q.pop_front();
            total++;
            if (e.t != cyc ||
                {sel_valid, busy, frame_done, a, b, c} !== {e.v, e.bz, e.fd, e.s}) begin
                bad++;
                $display("FAIL %s cyc=%0d got v=%b busy=%b fd=%b abc=%b%b%b want v=%b busy=%b fd=%b abc=%03b",
                         e.nm, cyc, sel_valid, busy, frame_done, a, b, c,
                         e.v, e.bz, e.fd, e.s);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic goto(input int t);
        while (cyc < t) step();
    endtask

    task automatic push(input int t, input string nm, input logic v, input logic bz,
                        input logic fd, input logic [2:0] s);
        exp_t e;
        e.t = t; e.nm = nm; e.v = v; e.bz = bz; e.fd = fd; e.s = s;
        q.push_back(e);
    endtask

    task automatic push_idle(input int t, input string nm);
        push(t, nm, 1'b0, 1'b0, 1'b0, 3'd0);
    endtask

    initial begin
        int c0;
        int s2[3];
        s2 = '{2, 5, 7};

        rst_n = 1'b0; start = 1'b0; stop = 1'b0; cont = 1'b0;
        mask = 8'h00; dwell = '0;
        step();
        push_idle(cyc, "reset");
        step();
        push_idle(cyc, "reset2");
        rst_n = 1'b1;

`ifdef SCAN_BLANK_EN
        // Blank cycles between channels and at frame end
        step();
        c0 = cyc; start = 1'b1; mask = 8'h03; dwell = 8'd1; cont = 1'b0;
        push(c0 + 1, "blk_ch0",   1'b1, 1'b1, 1'b0, 3'd0);
        push(c0 + 2, "blk_gap",   1'b0, 1'b1, 1'b0, 3'd0);
        push(c0 + 3, "blk_ch1",   1'b1, 1'b1, 1'b0, 3'd1);
        push(c0 + 4, "blk_end",   1'b0, 1'b1, 1'b1, 3'd1);
        push_idle(c0 + 5, "blk_idle");
        push_idle(c0 + 6, "blk_idle2");
        step(); start = 1'b0;
        goto(c0 + 7);
`else
        // Full mask, dwell 2, single frame
        step();
        c0 = cyc; start = 1'b1; mask = 8'hFF; dwell = 8'd2; cont = 1'b0;
        for (int k = 1; k <= 16; k++) push(c0 + k, "ff_scan", 1'b1, 1'b1, 1'b0, 3'((k - 1) / 2));
        push(c0 + 17, "ff_done", 1'b0, 1'b0, 1'b1, 3'd0);
        push_idle(c0 + 18, "ff_idle");
        step(); start = 1'b0;
        goto(c0 + 19);

        // Sparse mask, dwell 0, continuous, then stop
        c0 = cyc; start = 1'b1; mask = 8'b1010_0100; dwell = 8'd0; cont = 1'b1;
        for (int k = 1; k <= 9; k++)
            push(c0 + k, "sparse", 1'b1, 1'b1, (k >= 4 && (k - 1) % 3 == 0), 3'(s2[(k - 1) % 3]));
        push_idle(c0 + 10, "sparse_stop");
        step(); start = 1'b0;
        goto(c0 + 9); stop = 1'b1;
        step(); stop = 1'b0;
        goto(c0 + 11);

        // Mask change mid-frame only affects the next frame; start while busy ignored
        c0 = cyc; start = 1'b1; mask = 8'h0F; dwell = 8'd1; cont = 1'b1;
        for (int k = 1; k <= 8; k++) push(c0 + k, "mchg", 1'b1, 1'b1, (k == 5), 3'(k - 1));
        push(c0 + 9, "mchg_wrap", 1'b1, 1'b1, 1'b1, 3'd4);
        push_idle(c0 + 10, "mchg_stop");
        step(); start = 1'b0;
        goto(c0 + 2); mask = 8'hF0;
        goto(c0 + 6); start = 1'b1;
        step(); start = 1'b0;
        goto(c0 + 9); stop = 1'b1;
        step(); stop = 1'b0; cont = 1'b0;
        goto(c0 + 11);

        // Single-bit mask, continuous: channel held, frame_done every dwell cycles
        c0 = cyc; start = 1'b1; mask = 8'h10; dwell = 8'd3; cont = 1'b1;
        for (int k = 1; k <= 7; k++) push(c0 + k, "single", 1'b1, 1'b1, (k == 4 || k == 7), 3'd4);
        push_idle(c0 + 8, "single_stop");
        step(); start = 1'b0;
        goto(c0 + 7); stop = 1'b1;
        step(); stop = 1'b0; cont = 1'b0;
        goto(c0 + 9);

        // Stop while sel=3 with dwell 4, then start with empty mask
        c0 = cyc; start = 1'b1; mask = 8'hFF; dwell = 8'd4; cont = 1'b0;
        for (int k = 1; k <= 14; k++) push(c0 + k, "stop_scan", 1'b1, 1'b1, 1'b0, 3'((k - 1) / 4));
        push_idle(c0 + 15, "stop_idle");
        push_idle(c0 + 16, "stop_idle2");
        push_idle(c0 + 17, "empty_start");
        push_idle(c0 + 18, "empty_start2");
        step(); start = 1'b0;
        goto(c0 + 14); stop = 1'b1;
        step(); stop = 1'b0;
        goto(c0 + 16); mask = 8'h00; start = 1'b1;
        step(); start = 1'b0;
        goto(c0 + 19);

        // Reset mid-scan, then start and stop together
        c0 = cyc; start = 1'b1; mask = 8'hFF; dwell = 8'd3; cont = 1'b0;
        for (int k = 1; k <= 4; k++) push(c0 + k, "rst_scan", 1'b1, 1'b1, 1'b0, 3'((k - 1) / 3));
        push_idle(c0 + 5, "rst_mid");
        push_idle(c0 + 6, "rst_after");
        push_idle(c0 + 7, "start_stop");
        push_idle(c0 + 8, "start_stop2");
        step(); start = 1'b0;
        goto(c0 + 4); rst_n = 1'b0;
        step(); rst_n = 1'b1;
        goto(c0 + 6); start = 1'b1; stop = 1'b1;
        step(); start = 1'b0; stop = 1'b0;
        goto(c0 + 9);

        // Dwell change applies from the next channel entry
        c0 = cyc; start = 1'b1; mask = 8'h05; dwell = 8'd2; cont = 1'b0;
        push(c0 + 1, "dw_ch0", 1'b1, 1'b1, 1'b0, 3'd0);
        push(c0 + 2, "dw_ch0", 1'b1, 1'b1, 1'b0, 3'd0);
        for (int k = 3; k <= 5; k++) push(c0 + k, "dw_ch2", 1'b1, 1'b1, 1'b0, 3'd2);
        push(c0 + 6, "dw_done", 1'b0, 1'b0, 1'b1, 3'd0);
        push_idle(c0 + 7, "dw_idle");
        step(); start = 1'b0; dwell = 8'd3;
        goto(c0 + 8);
`endif

        step();
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain left=%0d want=0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Guard against a stalled run
    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d want finish", cyc);
        $fatal(1, "watchdog");
    end

endmodule
